// File: rtl/common_pkg.sv
// common: shared RV32 decode types, opcode constants and ALU op helper.
package common;

    typedef logic [31:0] instruction_type;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [2:0] {ENC_NONE, ENC_R, ENC_I, ENC_S, ENC_B, ENC_U, ENC_J} encoding_t;

    typedef struct packed {
        encoding_t  encoding;
        logic       RegWrite;
        logic       ALUSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       MemToReg;
        logic       Branch;
        logic       Jump;
        alu_op_t    ALUOp;
        logic [2:0] mem_size;
        logic [2:0] branch_cond;
    } control_type;

    typedef enum logic [1:0] {RUN, STALL, HALT} decode_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // alt selects SUB over ADD and SRA over SRL
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        return f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 ? ALU_SLT :
               f3 == 3'd3 ? ALU_SLTU :
               f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == 3'd6 ? ALU_OR :
               f3 == 3'd7 ? ALU_AND :
               alt ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I(+M) decode into control bundle and register usage.
module instr_decoder
    import common::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output control_type control,
    output logic        illegal,
    output logic        rs1_used,
    output logic        rs2_used
);

    control_type c;
    logic ok;

    always_comb begin
        c = '0;
        ok = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                c.encoding = ENC_U;
                c.RegWrite = 1'b1;
                c.ALUSrc = 1'b1;
                c.ALUOp = opcode == OP_LUI ? ALU_LUI : ALU_AUIPC;
                ok = 1'b1;
            end
            OP_JAL: begin
                c.encoding = ENC_J;
                c.RegWrite = 1'b1;
                c.Jump = 1'b1;
                ok = 1'b1;
            end
            OP_JALR: begin
                c.encoding = ENC_I;
                c.RegWrite = 1'b1;
                c.ALUSrc = 1'b1;
                c.Jump = 1'b1;
                ok = funct3 == 3'd0;
            end
            OP_BRANCH: begin
                c.encoding = ENC_B;
                c.Branch = 1'b1;
                c.branch_cond = funct3;
                c.ALUOp = !funct3[2] ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT;
                ok = funct3[2:1] != 2'b01;
            end
            OP_LOAD: begin
                c.encoding = ENC_I;
                c.RegWrite = 1'b1;
                c.ALUSrc = 1'b1;
                c.MemRead = 1'b1;
                c.MemToReg = 1'b1;
                c.mem_size = funct3;
                ok = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            OP_STORE: begin
                c.encoding = ENC_S;
                c.ALUSrc = 1'b1;
                c.MemWrite = 1'b1;
                c.mem_size = funct3;
                ok = funct3 inside {3'd0, 3'd1, 3'd2};
            end
            OP_IMM: begin
                c.encoding = ENC_I;
                c.RegWrite = 1'b1;
                c.ALUSrc = 1'b1;
                c.ALUOp = alu_from_f3(funct3, funct3 == 3'd5 && funct7 == F7_ALT);
                ok = funct3 == 3'd1 ? funct7 == F7_BASE :
                     funct3 == 3'd5 ? funct7 inside {F7_BASE, F7_ALT} : 1'b1;
            end
            OP_REG: begin
                c.encoding = ENC_R;
                c.RegWrite = 1'b1;
                c.ALUOp = funct7 == F7_MULDIV ? alu_op_t'(ALU_MUL + {2'b00, funct3}) :
                          alu_from_f3(funct3, funct7 == F7_ALT);
                ok = funct7 == F7_BASE ||
                     (funct7 == F7_ALT && funct3 inside {3'd0, 3'd5}) ||
                     (funct7 == F7_MULDIV && ENABLE_M);
            end
            default: ;
        endcase
    end

    assign control  = ok ? c : '0;
    assign illegal  = !ok;
    assign rs1_used = ok && c.encoding inside {ENC_R, ENC_I, ENC_S, ENC_B};
    assign rs2_used = ok && c.encoding inside {ENC_R, ENC_S, ENC_B};

endmodule

// File: rtl/decode_control_stage.sv
// decode_control_stage: registered ID stage with load-use stall, flush and illegal-instruction halt.
module decode_control_stage
    import common::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_M   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  instruction_type       in_instruction,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output control_type           out_control,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_pc,
    output logic                  out_illegal
);

    control_type dec_control;
    logic dec_illegal, rs1_used, rs2_used, hazard, free, accept;
    logic [REG_ADDR_W-1:0] rs1, rs2, rd;
    decode_state_t state, state_next;

    assign rs1 = in_instruction[15 +: REG_ADDR_W];
    assign rs2 = in_instruction[20 +: REG_ADDR_W];
    assign rd  = in_instruction[7 +: REG_ADDR_W];

    instr_decoder #(.ENABLE_M(ENABLE_M)) u_decoder (
        .opcode   (in_instruction[6:0]),
        .funct3   (in_instruction[14:12]),
        .funct7   (in_instruction[31:25]),
        .control  (dec_control),
        .illegal  (dec_illegal),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign free   = !out_valid || out_ready;
    assign hazard = in_valid && ex_mem_read && ex_rd != '0 &&
                    ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    assign in_ready = !rst && state == RUN && !flush && !hazard && free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = flush || state == STALL ? RUN :
                     state == RUN && hazard && free ? STALL :
                     accept && dec_illegal ? HALT : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= state_next;
    end

    // a stalled or drained cycle loads a bubble; backpressure holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_control <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush || (!accept && free)) begin
            out_valid   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_control <= dec_control;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_rd      <= rd;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_decode_control_stage.sv
// tb_decode_control_stage: directed scenarios plus randomized run against a pattern-table reference model.
module tb_decode_control_stage;
    import common::*;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, ex_mem_read = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [31:0] in_instruction = '0, in_pc = '0;
    logic [4:0] ex_rd = '0;
    logic in_ready, out_valid, out_illegal;
    control_type out_control;
    logic [4:0] out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc;

    logic m_valid = 1'b0;
    logic [31:0] m_instr = '0, m_pc = '0;
    logic m_in_ready, m_out_valid, m_out_illegal;
    control_type m_out_control;
    logic [4:0] m_out_rs1, m_out_rs2, m_out_rd;
    logic [31:0] m_out_pc;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    decode_control_stage #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_M(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_control(out_control), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    decode_control_stage #(.XLEN(32), .REG_ADDR_W(5), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_in_ready),
        .in_instruction(m_instr), .in_pc(m_pc), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_control(m_out_control), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
        .out_rd(m_out_rd), .out_pc(m_out_pc), .out_illegal(m_out_illegal)
    );

    // every legal instruction as mask/match with its ALU op and a class tag
    localparam int CU = 0, CJ = 1, CJR = 2, CB = 3, CLD = 4, CST = 5, CIM = 6, CR = 7, CM = 8;
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        alu_op_t     op;
        int          cls;
    } pat_t;
    pat_t pats[$];

    function automatic void pat(input logic [31:0] mask, input logic [31:0] match, input alu_op_t op, input int cls);
        pat_t p;
        p.mask = mask; p.match = match; p.op = op; p.cls = cls;
        pats.push_back(p);
    endfunction

    function automatic void init_pats();
        pat(32'h7F, 32'h37, ALU_LUI, CU);
        pat(32'h7F, 32'h17, ALU_AUIPC, CU);
        pat(32'h7F, 32'h6F, ALU_ADD, CJ);
        pat(32'h707F, 32'h67, ALU_ADD, CJR);
        pat(32'h707F, 32'h0063, ALU_SUB, CB);
        pat(32'h707F, 32'h1063, ALU_SUB, CB);
        pat(32'h707F, 32'h4063, ALU_SLT, CB);
        pat(32'h707F, 32'h5063, ALU_SLT, CB);
        pat(32'h707F, 32'h6063, ALU_SLTU, CB);
        pat(32'h707F, 32'h7063, ALU_SLTU, CB);
        pat(32'h707F, 32'h0003, ALU_ADD, CLD);
        pat(32'h707F, 32'h1003, ALU_ADD, CLD);
        pat(32'h707F, 32'h2003, ALU_ADD, CLD);
        pat(32'h707F, 32'h4003, ALU_ADD, CLD);
        pat(32'h707F, 32'h5003, ALU_ADD, CLD);
        pat(32'h707F, 32'h0023, ALU_ADD, CST);
        pat(32'h707F, 32'h1023, ALU_ADD, CST);
        pat(32'h707F, 32'h2023, ALU_ADD, CST);
        pat(32'h707F, 32'h0013, ALU_ADD, CIM);
        pat(32'h707F, 32'h2013, ALU_SLT, CIM);
        pat(32'h707F, 32'h3013, ALU_SLTU, CIM);
        pat(32'h707F, 32'h4013, ALU_XOR, CIM);
        pat(32'h707F, 32'h6013, ALU_OR, CIM);
        pat(32'h707F, 32'h7013, ALU_AND, CIM);
        pat(32'hFE00707F, 32'h00001013, ALU_SLL, CIM);
        pat(32'hFE00707F, 32'h00005013, ALU_SRL, CIM);
        pat(32'hFE00707F, 32'h40005013, ALU_SRA, CIM);
        pat(32'hFE00707F, 32'h00000033, ALU_ADD, CR);
        pat(32'hFE00707F, 32'h40000033, ALU_SUB, CR);
        pat(32'hFE00707F, 32'h00001033, ALU_SLL, CR);
        pat(32'hFE00707F, 32'h00002033, ALU_SLT, CR);
        pat(32'hFE00707F, 32'h00003033, ALU_SLTU, CR);
        pat(32'hFE00707F, 32'h00004033, ALU_XOR, CR);
        pat(32'hFE00707F, 32'h00005033, ALU_SRL, CR);
        pat(32'hFE00707F, 32'h40005033, ALU_SRA, CR);
        pat(32'hFE00707F, 32'h00006033, ALU_OR, CR);
        pat(32'hFE00707F, 32'h00007033, ALU_AND, CR);
        pat(32'hFE00707F, 32'h02000033, ALU_MUL, CM);
        pat(32'hFE00707F, 32'h02001033, ALU_MULH, CM);
        pat(32'hFE00707F, 32'h02002033, ALU_MULHSU, CM);
        pat(32'hFE00707F, 32'h02003033, ALU_MULHU, CM);
        pat(32'hFE00707F, 32'h02004033, ALU_DIV, CM);
        pat(32'hFE00707F, 32'h02005033, ALU_DIVU, CM);
        pat(32'hFE00707F, 32'h02006033, ALU_REM, CM);
        pat(32'hFE00707F, 32'h02007033, ALU_REMU, CM);
    endfunction

    function automatic void ref_decode(input logic [31:0] i, input bit m_en, output control_type c,
                                       output bit ill, output bit u1, output bit u2);
        c = '0;
        ill = 1'b1;
        foreach (pats[k]) begin
            if ((i & pats[k].mask) == pats[k].match && (pats[k].cls != CM || m_en)) begin
                ill = 1'b0;
                c.ALUOp = pats[k].op;
                case (pats[k].cls)
                    CU: begin c.encoding = ENC_U; c.RegWrite = 1; c.ALUSrc = 1; end
                    CJ: begin c.encoding = ENC_J; c.RegWrite = 1; c.Jump = 1; end
                    CJR: begin c.encoding = ENC_I; c.RegWrite = 1; c.ALUSrc = 1; c.Jump = 1; end
                    CB: begin c.encoding = ENC_B; c.Branch = 1; c.branch_cond = i[14:12]; end
                    CLD: begin
                        c.encoding = ENC_I; c.RegWrite = 1; c.ALUSrc = 1;
                        c.MemRead = 1; c.MemToReg = 1; c.mem_size = i[14:12];
                    end
                    CST: begin c.encoding = ENC_S; c.ALUSrc = 1; c.MemWrite = 1; c.mem_size = i[14:12]; end
                    CIM: begin c.encoding = ENC_I; c.RegWrite = 1; c.ALUSrc = 1; end
                    default: begin c.encoding = ENC_R; c.RegWrite = 1; end
                endcase
            end
        end
        u1 = !ill && c.encoding != ENC_U && c.encoding != ENC_J;
        u2 = !ill && (c.encoding == ENC_R || c.encoding == ENC_S || c.encoding == ENC_B);
    endfunction

    task automatic reset_dut();
        in_valid = 0; ex_mem_read = 0; flush = 0; out_ready = 1; m_valid = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_instruction = 32'h00500093; out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++;
        if ({out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal});
        end
        @(negedge clk);
        rst = 0; in_valid = 0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_valid = 1; in_instruction = 32'h00500093; in_pc = 32'h100;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        vectors++;
        if ({out_valid, out_control.ALUOp, out_control.ALUSrc, out_control.RegWrite, out_rd, out_pc, out_illegal}
            !== {1'b1, ALU_ADD, 1'b1, 1'b1, 5'd1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL basic_addi: valid=%b op=%0d src=%b wr=%b rd=%0d pc=%h ill=%b want 1/%0d/1/1/1/100/0",
                     out_valid, out_control.ALUOp, out_control.ALUSrc, out_control.RegWrite, out_rd, out_pc, out_illegal, ALU_ADD);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        in_valid = 1; in_instruction = 32'h001101B3; in_pc = 32'h200; ex_mem_read = 1; ex_rd = 2;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL load_use_blocks: got %b want 0", in_ready); end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got %b want 0", out_valid); end
        ex_mem_read = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_cycle_ready: got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL after_stall_ready: got %b want 1", in_ready); end
        @(negedge clk);
        vectors++;
        if ({out_valid, out_control.ALUOp, out_rd, out_pc} !== {1'b1, ALU_ADD, 5'd3, 32'h200}) begin
            errors++;
            $display("FAIL load_use_accept: valid=%b op=%0d rd=%0d pc=%h want 1/0/3/200", out_valid, out_control.ALUOp, out_rd, out_pc);
        end
        ex_mem_read = 1; ex_rd = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ex_rd_zero_no_stall: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0; ex_mem_read = 0;
    endtask

    task automatic test_m_ext();
        @(negedge clk);
        in_valid = 1; in_instruction = 32'h023100B3; in_pc = 32'h280;
        m_valid = 1; m_instr = 32'h023100B3; m_pc = 32'h280;
        #1;
        vectors++;
        if ({in_ready, m_in_ready} !== 2'b11) begin errors++; $display("FAIL mul_accept_ready: got %b want 11", {in_ready, m_in_ready}); end
        @(negedge clk);
        in_valid = 0; m_valid = 0;
        vectors++;
        if ({out_valid, out_illegal, out_control} !== {1'b1, 1'b1, 21'd0}) begin
            errors++;
            $display("FAIL mul_illegal: valid=%b ill=%b ctl=%h want 1/1/0", out_valid, out_illegal, out_control);
        end
        vectors++;
        if ({m_out_valid, m_out_illegal, m_out_control.ALUOp, m_out_control.RegWrite} !== {1'b1, 1'b0, ALU_MUL, 1'b1}) begin
            errors++;
            $display("FAIL mul_enabled: valid=%b ill=%b op=%0d wr=%b want 1/0/%0d/1", m_out_valid, m_out_illegal, m_out_control.ALUOp, m_out_control.RegWrite, ALU_MUL);
        end
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b want 0", in_ready); end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid = 1; in_instruction = 32'h00500093;
            #1;
            vectors++;
            if ({in_ready, out_valid, m_in_ready} !== 3'b001) begin
                errors++;
                $display("FAIL halt_hold %0d: ready=%b valid=%b m_ready=%b want 0/0/1", n, in_ready, out_valid, m_in_ready);
            end
        end
        @(negedge clk);
        flush = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        @(negedge clk);
        flush = 0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_exit_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        vectors++;
        if ({out_valid, out_rd, out_illegal} !== {1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL halt_exit_accept: valid=%b rd=%0d ill=%b want 1/1/0", out_valid, out_rd, out_illegal);
        end
    endtask

    task automatic test_backpressure();
        control_type c;
        bit ill, u1, u2;
        ref_decode(32'h0000A103, 1'b0, c, ill, u1, u2);
        @(negedge clk);
        in_valid = 1; in_instruction = 32'h0000A103; in_pc = 32'h300; out_ready = 1;
        @(negedge clk);
        out_ready = 0; in_instruction = 32'h00500093; in_pc = 32'h304;
        vectors++;
        if ({out_control.MemRead, out_control.MemToReg, out_rd} !== {2'b11, 5'd2}) begin
            errors++;
            $display("FAIL lw_decode: rd=%b m2r=%b rd=%0d want 1/1/2", out_control.MemRead, out_control.MemToReg, out_rd);
        end
        for (int n = 0; n < 3; n++) begin
            #1;
            vectors++;
            if ({in_ready, out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal}
                !== {1'b0, 1'b1, c, 5'd1, 5'd0, 5'd2, 32'h300, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold %0d: got %h want %h", n,
                         {in_ready, out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal},
                         {1'b0, 1'b1, c, 5'd1, 5'd0, 5'd2, 32'h300, 1'b0});
            end
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        vectors++;
        if ({out_rd, out_pc} !== {5'd1, 32'h304}) begin
            errors++;
            $display("FAIL after_backpressure: rd=%0d pc=%h want 1/304", out_rd, out_pc);
        end
    endtask

    task automatic test_flush_hazard();
        @(negedge clk);
        in_valid = 1; in_instruction = 32'h00500093; in_pc = 32'h500;
        @(negedge clk);
        out_ready = 0; in_instruction = 32'h001101B3; in_pc = 32'h5F0;
        ex_mem_read = 1; ex_rd = 2; flush = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_hazard_ready: got %b want 0", in_ready); end
        @(negedge clk);
        flush = 0; ex_mem_read = 0; out_ready = 1; in_valid = 0;
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clears_valid: got %b want 0", out_valid); end
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_stall: got %b want 1", in_ready); end
        in_valid = 1; in_pc = 32'h504;
        @(negedge clk);
        in_valid = 0;
        vectors++;
        if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd3, 32'h504}) begin
            errors++;
            $display("FAIL after_flush_accept: valid=%b rd=%0d pc=%h want 1/3/504", out_valid, out_rd, out_pc);
        end
    endtask

    task automatic test_reset_halt();
        @(negedge clk);
        in_valid = 1; in_instruction = 32'hFFFFFFFF; in_pc = 32'h600; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        vectors++;
        if ({out_valid, out_illegal, out_pc} !== {1'b1, 1'b1, 32'h600}) begin
            errors++;
            $display("FAIL halt_entry: valid=%b ill=%b pc=%h want 1/1/600", out_valid, out_illegal, out_pc);
        end
        #3 rst = 1;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal} !== '0) begin
            errors++;
            $display("FAIL async_reset_halt: got %h want 0", {in_ready, out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal});
        end
        @(negedge clk);
        rst = 0; out_ready = 1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_to_run: got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        logic m_valid_q = 0, m_ill = 0, m_stalled = 0, m_halted = 0, took = 0;
        control_type m_ctl = '0, c;
        logic [4:0] m_rs1 = 0, m_rs2 = 0, m_rd = 0;
        logic [31:0] m_pc = 0;
        bit ill, u1, u2, hz, free, er;
        int k;
        reset_dut();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal}
                !== {m_valid_q, m_ctl, m_rs1, m_rs2, m_rd, m_pc, m_ill}) begin
                errors++;
                $display("FAIL random_outputs cycle %0d: got %h want %h", n,
                         {out_valid, out_control, out_rs1, out_rs2, out_rd, out_pc, out_illegal},
                         {m_valid_q, m_ctl, m_rs1, m_rs2, m_rd, m_pc, m_ill});
            end
            if (!(in_valid && !took && $urandom_range(0, 3) != 0)) begin
                k = $urandom_range(0, pats.size() - 1);
                in_instruction = pats[k].match | ($urandom & ~pats[k].mask);
                if ($urandom_range(0, 19) == 0) in_instruction = $urandom;
                in_instruction[19:15] = 5'($urandom_range(0, 3));
                in_instruction[24:20] = 5'($urandom_range(0, 3));
                in_pc = $urandom;
            end
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd = 5'($urandom_range(0, 3));
            flush = m_halted ? $urandom_range(0, 3) == 0 : $urandom_range(0, 24) == 0;
            #1;
            ref_decode(in_instruction, 1'b0, c, ill, u1, u2);
            hz = in_valid && ex_mem_read && ex_rd != 0 &&
                 ((u1 && ex_rd == in_instruction[19:15]) || (u2 && ex_rd == in_instruction[24:20]));
            free = !m_valid_q || out_ready;
            er = !m_halted && !m_stalled && !flush && !hz && free;
            vectors++;
            if (in_ready !== er) begin
                errors++;
                $display("FAIL random_in_ready cycle %0d: got %b want %b", n, in_ready, er);
            end
            took = in_valid && er;
            if (flush) begin
                m_valid_q = 0; m_ill = 0; m_stalled = 0; m_halted = 0;
            end else begin
                m_stalled = !m_stalled && !m_halted && hz && free;
                if (took) begin
                    m_valid_q = 1; m_ctl = c; m_ill = ill; m_halted = ill; m_pc = in_pc;
                    m_rs1 = in_instruction[19:15]; m_rs2 = in_instruction[24:20]; m_rd = in_instruction[11:7];
                end else if (free) begin
                    m_valid_q = 0; m_ill = 0;
                end
            end
        end
        @(negedge clk);
        in_valid = 0; flush = 0;
    endtask

    initial begin
        init_pats();
        test_reset();
        test_basic();
        test_load_use();
        test_m_ext();
        test_backpressure();
        test_flush_hazard();
        test_reset_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
